// File: rtl/dot_scan_scheduler_pkg.sv
// Shared types and helpers for the dot-matrix scan scheduler.
// Geometry constants, row/column types, active-low row select.
package dot_scan_scheduler_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 16;

  typedef logic [2:0]      row_idx_t;
  typedef logic [COLS-1:0] col_pat_t;

  // Active-low one-hot row select; row 0 maps to bit 7.
  function automatic logic [ROWS-1:0] row_sel_low(row_idx_t r);
    return ~(8'h80 >> r);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with combinational grants.
// Ports: clk, rst (async low), req_a/req_b, commit, gnt_a/gnt_b.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic commit,
  output logic gnt_a,
  output logic gnt_b
);

  // 0: A holds priority, 1: B holds priority
  logic prio_q;

  always_comb begin
    gnt_a = req_a & (~req_b | ~prio_q);
    gnt_b = req_b & ~gnt_a;
  end

  // Priority moves away from whoever was just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (commit & gnt_a) begin
      prio_q <= 1'b1;
    end else if (commit & gnt_b) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dot_scan_scheduler.sv
// Double-buffered 8x16 dot-matrix scanner with two arbitrated writers.
// Ports: clk, rst (async low), req/row/data/gnt for A and B, swap_req,
//        swap_done, frame_start, dot_row (active-low), dot_col.
module dot_scan_scheduler
  import dot_scan_scheduler_pkg::*;
#(
  parameter int DIV = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [2:0]  a_row,
  input  logic [15:0] a_data,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [2:0]  b_row,
  input  logic [15:0] b_data,
  output logic        gnt_b,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        frame_start,
  output logic [7:0]  dot_row,
  output logic [15:0] dot_col
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  col_pat_t      back_q  [ROWS];
  col_pat_t      front_q [ROWS];
  logic [CW-1:0] cnt_q;
  row_idx_t      row_q;
  row_idx_t      row_nx;
  logic          pend_q;
  logic          tick;
  logic          wrap;
  logic          do_swap;
  logic          wr_en;
  row_idx_t      wr_row;
  col_pat_t      wr_data;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .commit (rst),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_comb begin
    wr_en   = gnt_a | gnt_b;
    wr_row  = gnt_a ? a_row : b_row;
    wr_data = gnt_a ? a_data : b_data;
    tick    = (cnt_q == TERM);
    row_nx  = row_q + row_idx_t'(1);
    wrap    = tick & (row_q == row_idx_t'(7));
    do_swap = wrap & pend_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) back_q[i] <= '0;
    end else if (wr_en) begin
      back_q[wr_row] <= wr_data;
    end
  end

  // Front takes the pre-write back image on the swap edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) front_q[i] <= '0;
    end else if (do_swap) begin
      for (int i = 0; i < ROWS; i++) front_q[i] <= back_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      row_q       <= row_idx_t'(7);
      pend_q      <= 1'b0;
      swap_done   <= 1'b0;
      frame_start <= 1'b0;
      dot_row     <= 8'hFF;
      dot_col     <= '0;
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + CW'(1);
      swap_done   <= do_swap;
      frame_start <= wrap;
      if (do_swap) begin
        pend_q <= swap_req;
      end else if (swap_req) begin
        pend_q <= 1'b1;
      end
      if (tick) begin
        row_q   <= row_nx;
        dot_row <= row_sel_low(row_nx);
        // Row 0 of a swapping frame bypasses the front load.
        dot_col <= do_swap ? back_q[0] : front_q[row_nx];
      end
    end
  end

endmodule

// File: doc/dot_scan_scheduler.md
DOT_SCAN_SCHEDULER -- requirements
Module: dot_scan_scheduler

Interface
REQ-001 Parameter DIV, default 5000, meaning clk cycles per scanned row (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  row-write request from obstacle layer.
REQ-005 a_row  input  3  row index for requester A.
REQ-006 a_data  input  16  column pattern for requester A, bit 15 = leftmost.
REQ-007 gnt_a  output  1  write grant to A; write commits on the edge where req_a & gnt_a.
REQ-008 req_b, b_row, b_data, gnt_b  same widths and meaning for player layer B.
REQ-009 swap_req  input  1  one-cycle request to publish back buffer to display.
REQ-010 swap_done  output  1  one-cycle pulse when publish has occurred.
REQ-011 frame_start  output  1  one-cycle pulse when scan returns to row 0.
REQ-012 dot_row  output  8  active-low one-hot row select, bit 7 = row 0.
REQ-013 dot_col  output  16  active-high column drive for selected row.

Function
REQ-014 Block SHALL hold two 8x16 buffers: back (written by requesters) and front (scanned).
REQ-015 gnt_a/gnt_b SHALL be combinational from req_a, req_b and priority bit; at most one grant per cycle.
REQ-016 Single requester active SHALL be granted the same cycle, regardless of priority.
REQ-017 Both active: grant SHALL go to priority holder; priority SHALL then pass to the other requester.
REQ-018 Priority SHALL update only on a committed grant; idle cycles leave it unchanged.
REQ-019 Committed write SHALL replace back[row] entirely with the granted data.
REQ-020 Prescaler SHALL count 0..DIV-1; terminal count is a scan tick.
REQ-021 On scan tick, row index SHALL advance modulo 8; dot_row <= ~(8'h80 >> next_row) and dot_col <= front[next_row] on the same edge.
REQ-022 Between ticks dot_row and dot_col SHALL hold; front changes SHALL NOT affect dot_col until next tick.
REQ-023 frame_start SHALL pulse for the cycle following the tick on which row wraps 7->0.
REQ-024 swap_req SHALL set a pending flag; further swap_req while pending SHALL be merged (no second swap).
REQ-025 On the 7->0 wrap tick with pending set, front SHALL be loaded with all 8 back rows in one cycle and pending cleared; swap_done pulses the next cycle.
REQ-026 A write committed on the swap edge SHALL land in back only; front receives pre-write back contents.
REQ-027 swap_req arriving on the swap edge itself SHALL set pending for the next frame.
REQ-028 Row 0 displayed after a swap SHALL already show new front[0] (load and row-0 output use same-edge bypass of back[0]).

Reset
REQ-029 rst low SHALL immediately force: dot_row 8'hFF, dot_col 0, gnt-independent state cleared, row index 7, prescaler 0, priority A, pending 0, swap_done 0, frame_start 0, both buffers all-zero.
REQ-030 After rst release, first tick SHALL display row 0; reset mid-scan or mid-swap SHALL discard pending swap and buffer contents.
REQ-031 gnt outputs SHALL follow REQ-015..017 combinationally even during reset, but no write commits while rst low.

Structure
REQ-032 Shared package SHALL hold ROWS=8, COLS=16, row-index and column-pattern types, and the onehot-low row-select function.
REQ-033 Two-way round-robin arbiter SHALL be a sub-module named rr_arbiter2 (req_a, req_b, commit, gnt_a, gnt_b, priority state).

Verification (DIV=4)
REQ-034 Reset release, no writes -> dot_row steps 7F,BF,DF,EF,F7,FB,FD,FE every 4 cycles, dot_col 0, frame_start each 32 cycles.
REQ-035 req_a and req_b held 4 cycles -> grants A,B,A,B; back rows reflect the last data of each.
REQ-036 Write back[3]=16'hC000, swap_req mid-frame -> front unchanged until wrap; swap_done one cycle after wrap; row 3 shows C000 in that frame.
REQ-037 swap_req twice in one frame -> exactly one swap_done.
REQ-038 Write to row 0 on the swap edge -> not visible this frame; visible after next swap.
REQ-039 rst asserted during row 5 with pending swap -> outputs FF/0000 immediately, no swap_done after release.
